ps2_rx_fifo_keyboard: RTL and testbench

Parametrised PS/2 device-to-host receiver with glitch filtering, full frame checking (start, odd parity, stop) and a watchdog timeout.
- Optionally merges E0/F0 prefixes into per-code flags.
- Buffers decoded codes in a show-ahead FIFO behind a valid/ready interface.
- Sits between the keyboard pins and the Spectrum keyboard matrix / host logic, and replaces the single-register, strobe-only receiver.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_sync_fifo.sv | 61 ++++++
 rtl/ps2_rx_fifo_keyboard.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_rx_fifo_keyboard.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 receive path.
package ps2_pkg;

    localparam logic [7:0] EXTEND_CODE  = 8'hE0;
    localparam logic [7:0] RELEASE_CODE = 8'hF0;
    localparam int         FRAME_BITS   = 11;   // start, 8 data, parity, stop

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        CHECK
    } ps2_state_t;

    // One FIFO entry: prefix flags above the scan code
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    // Data bits plus parity bit must contain an odd number of ones
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; read and write may
// coincide, including when full.
module ps2_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_rd   = rd_en & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign do_wr   = wr_en & (~full | do_rd);
    // Masked head keeps the output at zero while nothing is stored
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and count bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; stale contents are
        // unreachable because the read side is masked by the count.
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ps2_rx_fifo_keyboard.sv
// PS/2 device-to-host receiver: synchroniser, clock glitch filter, frame
// FSM with parity/stop checking and watchdog, prefix merging, output FIFO.
module ps2_rx_fifo_keyboard
    import ps2_pkg::*;
#(
    parameter int CLK_KHZ      = 28000,
    parameter int TIMEOUT_US   = 60,
    parameter int FILTER_LEN   = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int MERGE_PREFIX = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [7:0]                    code,
    output logic                          code_ext,
    output logic                          code_rel,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_timeout,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TIMEOUT_CYC = CLK_KHZ * TIMEOUT_US / 1000;
    localparam int WD_W        = $clog2(TIMEOUT_CYC + 1);
    localparam int FLT_W       = $clog2(FILTER_LEN + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_s;
    logic             data_s;
    logic             clk_f;
    logic [FLT_W-1:0] flt_cnt;
    logic             clk_fall;
    logic             clk_edge;

    ps2_state_t       state;
    ps2_state_t       state_next;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift_reg;   // data[7:0], parity, stop once complete
    logic [WD_W-1:0]  wd_cnt;
    logic             ext_pend;
    logic             rel_pend;

    logic             byte_good;
    logic             is_prefix;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    fifo_entry_t      wr_entry;
    fifo_entry_t      head;
    logic [ENTRY_W-1:0] rd_bits;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Clock filter: follow the input only after FILTER_LEN agreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_f    <= 1'b1;
            flt_cnt  <= '0;
            clk_fall <= 1'b0;
            clk_edge <= 1'b0;
        end else begin
            clk_fall <= 1'b0;
            clk_edge <= 1'b0;
            if (clk_s != clk_f) begin
                if (flt_cnt == FLT_LAST) begin
                    clk_f    <= clk_s;
                    flt_cnt  <= '0;
                    clk_edge <= 1'b1;
                    clk_fall <= ~clk_s;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and single-cycle status pulses
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next  = state;
        err_parity  = 1'b0;
        err_frame   = 1'b0;
        err_timeout = 1'b0;
        byte_good   = 1'b0;
        case (state)
            IDLE: begin
                if (clk_fall && !data_s) state_next = RECV;
            end
            RECV: begin
                if (clk_fall && bit_cnt == LAST_BIT) begin
                    state_next = CHECK;
                end else if (!clk_edge && wd_cnt == WD_LAST) begin
                    err_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (!odd_parity_ok(shift_reg[8:0])) err_parity = 1'b1;
                else if (!shift_reg[9])             err_frame  = 1'b1;
                else                                byte_good  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign is_prefix = (MERGE_PREFIX != 0) &&
                       (shift_reg[7:0] == EXTEND_CODE || shift_reg[7:0] == RELEASE_CODE);
    assign push      = byte_good && !is_prefix;
    assign pop       = code_valid & code_ready;
    assign wr_entry  = '{ext: ext_pend, rel: rel_pend, code: shift_reg[7:0]};

    // Bit shifting, bit count, watchdog, prefix flags and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            wd_cnt    <= '0;
            ext_pend  <= 1'b0;
            rel_pend  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (state == IDLE && state_next == RECV) begin
                bit_cnt <= 4'd1;
                wd_cnt  <= '0;
            end
            if (state == RECV) begin
                wd_cnt <= clk_edge ? '0 : wd_cnt + 1'b1;
                if (clk_fall) begin
                    shift_reg <= {data_s, shift_reg[9:1]};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
            end
            if (err_parity || err_frame || err_timeout) begin
                ext_pend <= 1'b0;
                rel_pend <= 1'b0;
            end else if (byte_good) begin
                if (is_prefix && shift_reg[7:0] == EXTEND_CODE) begin
                    ext_pend <= 1'b1;
                end else if (is_prefix) begin
                    rel_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    rel_pend <= 1'b0;
                end
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    ps2_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_bits),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head       = fifo_entry_t'(rd_bits);
    assign code_valid = ~fifo_empty;
    assign code       = head.code;
    assign code_ext   = head.ext;
    assign code_rel   = head.rel;

endmodule

// File: tb/tb_ps2_rx_fifo_keyboard.sv
// Directed bench for the PS/2 receiver: one task per scenario, inline checks.
module tb_ps2_rx_fifo_keyboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       code_ready;
    logic       code_ready_raw;

    logic       code_valid, code_ext, code_rel;
    logic [7:0] code;
    logic       err_parity, err_frame, err_timeout, overflow;
    logic [3:0] fifo_count;

    logic       raw_valid, raw_ext, raw_rel;
    logic [7:0] raw_code;
    logic       raw_par, raw_frm, raw_to, raw_ovf;
    logic [3:0] raw_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_par    = 0;
    int n_frm    = 0;
    int n_to     = 0;

    ps2_rx_fifo_keyboard dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_valid(code_valid), .code_ready(code_ready), .code(code),
        .code_ext(code_ext), .code_rel(code_rel), .err_parity(err_parity),
        .err_frame(err_frame), .err_timeout(err_timeout), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    ps2_rx_fifo_keyboard #(.MERGE_PREFIX(0)) dut_raw (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code_valid(raw_valid), .code_ready(code_ready_raw), .code(raw_code),
        .code_ext(raw_ext), .code_rel(raw_rel), .err_parity(raw_par),
        .err_frame(raw_frm), .err_timeout(raw_to), .overflow(raw_ovf),
        .fifo_count(raw_count)
    );

    always #5 clk = ~clk;

    // Tally error pulses away from the active edge
    always @(negedge clk) begin
        if (err_parity === 1'b1)  n_par++;
        if (err_frame === 1'b1)   n_frm++;
        if (err_timeout === 1'b1) n_to++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(10);
        ps2_clk = 1'b0;
        tick(20);
        ps2_clk = 1'b1;
        tick(10);
    endtask

    // Start bit, eight data bits LSB first, parity (odd unless flipped)
    task automatic send_head(input logic [7:0] b, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ par_flip);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_head(b, par_flip);
        send_bit(stop);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        ps2_clk = 1'b1; ps2_data = 1'b1; code_ready = 1'b0; code_ready_raw = 1'b0;
        reset = 1'b1;
        tick(3);
        n_checks++;
        if ({code_valid, code, code_ext, code_rel, err_parity, err_frame, err_timeout,
             overflow, fifo_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b code=%h ext=%b rel=%b cnt=%0d ovf=%b, expected all 0",
                     code_valid, code, code_ext, code_rel, fifo_count, overflow);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        do_reset();
        code_ready = 1'b1;
        send_head(8'h1C, 1'b0);
        ps2_data = 1'b1;
        tick(10);
        ps2_clk = 1'b0;
        tick(7);
        n_checks++;
        if (code_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_latency_early: valid=%b expected 0", code_valid);
        end
        tick(1);
        n_checks++;
        if ({code_valid, code_ext, code_rel, code} !== {3'b100, 8'h1C}) begin
            n_fail++;
            $display("FAIL basic_head: got valid=%b ext=%b rel=%b code=%h expected 1 0 0 1c",
                     code_valid, code_ext, code_rel, code);
        end
        tick(12);
        ps2_clk = 1'b1;
        tick(10);
        n_checks++;
        if ({code_valid, fifo_count} !== 5'd0) begin
            n_fail++; $display("FAIL basic_single: valid=%b count=%0d expected 0 0", code_valid, fifo_count);
        end
        code_ready = 1'b0;
    endtask

    task automatic test_prefix;
        logic [7:0] exp_raw [3];
        exp_raw = '{8'hE0, 8'hF0, 8'h75};
        do_reset();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        n_checks++;
        if (fifo_count !== 4'd1) begin
            n_fail++; $display("FAIL prefix_count: got %0d expected 1", fifo_count);
        end
        n_checks++;
        if ({code_ext, code_rel, code} !== {2'b11, 8'h75}) begin
            n_fail++; $display("FAIL prefix_head: got ext=%b rel=%b code=%h expected 1 1 75",
                               code_ext, code_rel, code);
        end
        n_checks++;
        if (raw_count !== 4'd3) begin
            n_fail++; $display("FAIL raw_count: got %0d expected 3", raw_count);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({raw_valid, raw_ext, raw_rel, raw_code} !== {3'b100, exp_raw[i]}) begin
                n_fail++;
                $display("FAIL raw_entry%0d: got valid=%b ext=%b rel=%b code=%h expected 1 0 0 %h",
                         i, raw_valid, raw_ext, raw_rel, raw_code, exp_raw[i]);
            end
            code_ready_raw = 1'b1;
            tick(1);
            code_ready_raw = 1'b0;
        end
    endtask

    task automatic test_errors;
        int base_par, base_frm;
        do_reset();
        base_par = n_par;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        n_checks++;
        if (n_par - base_par !== 1) begin
            n_fail++; $display("FAIL parity_pulses: got %0d expected 1", n_par - base_par);
        end
        n_checks++;
        if ({fifo_count, code_ext, code_rel, code} !== {4'd1, 2'b00, 8'h75}) begin
            n_fail++; $display("FAIL parity_head: got cnt=%0d ext=%b rel=%b code=%h expected 1 0 0 75",
                               fifo_count, code_ext, code_rel, code);
        end
        code_ready = 1'b1;
        tick(1);
        code_ready = 1'b0;
        base_frm = n_frm;
        base_par = n_par;
        send_frame(8'h33, 1'b0, 1'b0);
        n_checks++;
        if ({n_frm - base_frm, n_par - base_par} !== {32'd1, 32'd0}) begin
            n_fail++; $display("FAIL frame_pulses: got frame=%0d parity=%0d expected 1 0",
                               n_frm - base_frm, n_par - base_par);
        end
        n_checks++;
        if (fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL frame_no_entry: got count %0d expected 0", fifo_count);
        end
    endtask

    task automatic test_timeout;
        int base_to, t, found;
        do_reset();
        base_to = n_to;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        // Last rising edge of ps2_clk was driven 10 cycles ago
        t = 10;
        found = -1;
        while (t < 2000) begin
            tick(1);
            t++;
            if (err_timeout === 1'b1 && found < 0) found = t;
        end
        n_checks++;
        if (found < 1680 || found > 1692) begin
            n_fail++; $display("FAIL timeout_cycle: pulse at %0d cycles after edge, expected 1680..1692", found);
        end
        n_checks++;
        if (n_to - base_to !== 1) begin
            n_fail++; $display("FAIL timeout_pulses: got %0d expected 1", n_to - base_to);
        end
        send_frame(8'h29, 1'b0, 1'b1);
        n_checks++;
        if ({fifo_count, code_ext, code_rel, code} !== {4'd1, 2'b00, 8'h29}) begin
            n_fail++; $display("FAIL timeout_recover: got cnt=%0d ext=%b rel=%b code=%h expected 1 0 0 29",
                               fifo_count, code_ext, code_rel, code);
        end
    endtask

    task automatic test_overflow;
        do_reset();
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b1);
        n_checks++;
        if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
            n_fail++; $display("FAIL fill: got cnt=%0d ovf=%b expected 8 0", fifo_count, overflow);
        end
        // Pop exactly in the push cycle of frame 09
        send_head(8'h09, 1'b0);
        ps2_data = 1'b1;
        tick(10);
        ps2_clk = 1'b0;
        tick(7);
        code_ready = 1'b1;
        tick(1);
        code_ready = 1'b0;
        tick(12);
        ps2_clk = 1'b1;
        tick(10);
        n_checks++;
        if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
            n_fail++; $display("FAIL push_pop_full: got cnt=%0d ovf=%b expected 8 0", fifo_count, overflow);
        end
        send_frame(8'h0A, 1'b0, 1'b1);
        n_checks++;
        if ({fifo_count, overflow} !== {4'd8, 1'b1}) begin
            n_fail++; $display("FAIL overflow: got cnt=%0d ovf=%b expected 8 1", fifo_count, overflow);
        end
        for (int i = 2; i <= 9; i++) begin
            n_checks++;
            if ({code_valid, code} !== {1'b1, 8'(i)}) begin
                n_fail++; $display("FAIL drain_%0d: got valid=%b code=%h expected 1 %h",
                                   i, code_valid, code, 8'(i));
            end
            code_ready = 1'b1;
            tick(1);
            code_ready = 1'b0;
        end
        n_checks++;
        if ({code_valid, fifo_count, overflow} !== {1'b0, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL drained: got valid=%b cnt=%0d ovf=%b expected 0 0 1",
                               code_valid, fifo_count, overflow);
        end
        // Pop on an empty FIFO must not disturb anything
        code_ready = 1'b1;
        tick(2);
        code_ready = 1'b0;
        n_checks++;
        if ({code_valid, fifo_count} !== 5'd0) begin
            n_fail++; $display("FAIL pop_empty: got valid=%b cnt=%0d expected 0 0", code_valid, fifo_count);
        end
    endtask

    task automatic test_glitch_and_reset;
        int base_par, base_frm, base_to;
        do_reset();
        base_par = n_par; base_frm = n_frm; base_to = n_to;
        ps2_data = 1'b0;
        tick(5);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(30);
        ps2_data = 1'b1;
        tick(10);
        n_checks++;
        if (fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL glitch_entry: got count %0d expected 0", fifo_count);
        end
        send_frame(8'h5A, 1'b0, 1'b1);
        n_checks++;
        if ({fifo_count, code} !== {4'd1, 8'h5A}) begin
            n_fail++; $display("FAIL glitch_frame: got cnt=%0d code=%h expected 1 5a", fifo_count, code);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        tick(2);
        n_checks++;
        if ({code_valid, code, code_ext, code_rel, err_parity, err_frame, err_timeout,
             overflow, fifo_count} !== 19'd0) begin
            n_fail++; $display("FAIL midframe_reset: got valid=%b code=%h cnt=%0d ovf=%b expected all 0",
                               code_valid, code, fifo_count, overflow);
        end
        reset = 1'b0;
        tick(1);
        send_frame(8'h66, 1'b0, 1'b1);
        n_checks++;
        if ({fifo_count, code_ext, code_rel, code} !== {4'd1, 2'b00, 8'h66}) begin
            n_fail++; $display("FAIL after_reset: got cnt=%0d ext=%b rel=%b code=%h expected 1 0 0 66",
                               fifo_count, code_ext, code_rel, code);
        end
        n_checks++;
        if ({n_par - base_par, n_frm - base_frm, n_to - base_to} !== 96'd0) begin
            n_fail++; $display("FAIL stray_errors: got par=%0d frm=%0d to=%0d expected 0 0 0",
                               n_par - base_par, n_frm - base_frm, n_to - base_to);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_errors();
        test_timeout();
        test_overflow();
        test_glitch_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
